// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the Wishbone memory arbiter and its round-robin
// picker: the arbiter state encoding, the reset value of the "last granted"
// pointer and the width of the optional watchdog counter.
// Optional feature: WB_ARB_WATCHDOG_EN (the watchdog itself lives in
// wb_mem_arbiter; this package only provides its counter width).
// -----------------------------------------------------------------------------
package wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Watchdog counter width; TIMEOUT must fit in it.
   localparam int WDOG_W = 16;

   // Reset value of the "last granted" pointer. Starting at N-1 makes the
   // first round-robin scan begin at master 0.
   function automatic int last_reset(input int n);
      return n - 1;
   endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// wb_arb_rr_pick
// Purely combinational round-robin picker. Scans the request vector starting
// one position above last_i (modulo N) and returns the first requester.
//
// Parameters:
//   N        number of requesters (>= 2)
//   GW       index width, $clog2(N)
// Ports:
//   req_i    [N-1:0]   request vector
//   last_i   [GW-1:0]  index of the most recently served requester
//   win_o    [GW-1:0]  winning index (0 when valid_o is low)
//   valid_o            at least one request present
// -----------------------------------------------------------------------------
module wb_arb_rr_pick #(
   parameter int N  = 2,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [GW-1:0] last_i,
   output logic [GW-1:0] win_o,
   output logic          valid_o
);

   logic [GW-1:0] win;
   logic          vld;
   int            idx;

   always_comb begin
      win = '0;
      vld = 1'b0;
      idx = 0;
      // Offsets 1..N visit every requester once, ending with last_i itself,
      // so a lone requester that was just served can still win.
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_i) + k) % N;
         if (!vld && req_i[idx]) begin
            vld = 1'b1;
            win = GW'(idx);
         end
      end
   end

   assign win_o   = win;
   assign valid_o = vld;

endmodule

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
// Round-robin Wishbone classic arbiter sharing one slave between N masters.
// The winning master keeps the grant for its whole cyc (bus lock); releasing
// cyc costs one IDLE cycle before the next grant.
//
// Optional feature: define WB_ARB_WATCHDOG_EN to compile in a watchdog that
// ends a transfer with m_err after TIMEOUT unacknowledged wait states.
//
// Parameters: N (masters), AW (address width), DW (data width),
//             TIMEOUT (watchdog wait-state limit, 1..65535)
// Ports:
//   wb_clk, wb_rst            clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we [N]      per-master control
//   m_adr [N*AW]              packed addresses, master i at [i*AW +: AW]
//   m_dat [N*DW]              packed write data
//   m_sel [N*DW/8]            packed byte selects
//   m_rdt [DW]                slave read data, broadcast
//   m_ack/m_err [N]           per-master response
//   s_cyc/s_stb/s_we          slave control
//   s_adr/s_dat/s_sel         slave address, write data, byte selects
//   s_rdt, s_ack, s_err       slave response
//   o_grant [$clog2(N)]       granted master, valid while o_busy
//   o_busy                    arbiter in BUSY state
// -----------------------------------------------------------------------------
module wb_mem_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N       = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                   wb_clk,
   input  logic                   wb_rst,
   input  logic [N-1:0]           m_cyc,
   input  logic [N-1:0]           m_stb,
   input  logic [N-1:0]           m_we,
   input  logic [N*AW-1:0]        m_adr,
   input  logic [N*DW-1:0]        m_dat,
   input  logic [N*(DW/8)-1:0]    m_sel,
   output logic [DW-1:0]          m_rdt,
   output logic [N-1:0]           m_ack,
   output logic [N-1:0]           m_err,
   output logic                   s_cyc,
   output logic                   s_stb,
   output logic                   s_we,
   output logic [AW-1:0]          s_adr,
   output logic [DW-1:0]          s_dat,
   output logic [DW/8-1:0]        s_sel,
   input  logic [DW-1:0]          s_rdt,
   input  logic                   s_ack,
   input  logic                   s_err,
   output logic [$clog2(N)-1:0]   o_grant,
   output logic                   o_busy
);

   localparam int GW = $clog2(N);
   localparam int SW = DW / 8;

   if (N < 2 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("wb_mem_arbiter: N must be >= 2 and TIMEOUT in 1..65535");
   end

   arb_state_t    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_q, last_d;

   logic [N-1:0]  req;
   logic [GW-1:0] pick_win;
   logic          pick_vld;
   logic          busy;
   logic          g_cyc;
   logic          g_stb;
   logic          timeout;

   assign req   = m_cyc & m_stb;
   assign busy  = (state_q == BUSY);
   assign g_cyc = m_cyc[grant_q];
   assign g_stb = m_stb[grant_q];

   wb_arb_rr_pick #(
      .N  (N),
      .GW (GW)
   ) u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .win_o   (pick_win),
      .valid_o (pick_vld)
   );

`ifdef WB_ARB_WATCHDOG_EN
   logic [WDOG_W-1:0] wdog_q, wdog_d;

   // An ack in the timeout cycle completes the transfer normally.
   assign timeout = busy & (wdog_q == WDOG_W'(TIMEOUT)) & ~s_ack;

   // Counts consecutive unanswered strobe cycles; s_stb is already forced low
   // in the timeout cycle, so the counter clears as the grant is dropped.
   always_comb begin
      wdog_d = '0;
      if (busy && s_stb && !s_ack && !s_err) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state logic for the arbiter FSM.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      if (state_q == IDLE) begin
         if (pick_vld) begin
            grant_d = pick_win;
            state_d = BUSY;
         end
      end else begin
         // Release (or watchdog abort) makes the current master lowest
         // priority for the next scan.
         if (!g_cyc || timeout) begin
            state_d = IDLE;
            last_d  = grant_q;
         end
      end
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(last_reset(N));
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Request/response routing. Everything here is combinational from
   // state_q, so an asynchronous reset silences the slave port at once.
   // Gating ack/err with the master's cyc drops responses to an abandoned
   // transfer.
   always_comb begin
      s_cyc = 1'b0;
      s_stb = 1'b0;
      s_we  = 1'b0;
      s_adr = '0;
      s_dat = '0;
      s_sel = '0;
      m_rdt = '0;
      m_ack = '0;
      m_err = '0;
      if (busy) begin
         s_cyc          = g_cyc & ~timeout;
         s_stb          = g_stb & ~timeout;
         s_we           = m_we[grant_q];
         s_adr          = m_adr[grant_q*AW +: AW];
         s_dat          = m_dat[grant_q*DW +: DW];
         s_sel          = m_sel[grant_q*SW +: SW];
         m_rdt          = s_rdt;
         m_ack[grant_q] = s_ack & g_cyc;
         m_err[grant_q] = (s_err & g_cyc) | timeout;
      end
   end

   assign o_busy  = busy;
   assign o_grant = grant_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
// Bench for wb_mem_arbiter with N=2, TIMEOUT=8. The bench plays both CPU
// masters and the slave. Every ack the bench issues pushes {master, rdt}
// onto exp_q; a negedge monitor pops and compares whenever m_ack is seen.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

   localparam int N       = 2;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int SW      = DW / 8;
   localparam int TIMEOUT = 8;

   logic                 wb_clk = 1'b0;
   logic                 wb_rst;
   logic [N-1:0]         m_cyc;
   logic [N-1:0]         m_stb;
   logic [N-1:0]         m_we;
   logic [N*AW-1:0]      m_adr;
   logic [N*DW-1:0]      m_dat;
   logic [N*SW-1:0]      m_sel;
   logic [DW-1:0]        m_rdt;
   logic [N-1:0]         m_ack;
   logic [N-1:0]         m_err;
   logic                 s_cyc;
   logic                 s_stb;
   logic                 s_we;
   logic [AW-1:0]        s_adr;
   logic [DW-1:0]        s_dat;
   logic [SW-1:0]        s_sel;
   logic [DW-1:0]        s_rdt;
   logic                 s_ack;
   logic                 s_err;
   logic [$clog2(N)-1:0] o_grant;
   logic                 o_busy;

   int checks = 0;
   int errors = 0;

   // Scoreboard: {master index, read data} for every ack the slave gives.
   logic [DW:0] exp_q[$];
   logic [DW:0] mon_got;
   logic [DW:0] mon_exp;

   localparam logic [AW-1:0] A0 = 32'h0000_1000;
   localparam logic [AW-1:0] A1 = 32'h0000_2000;

   wb_mem_arbiter #(
      .N       (N),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .wb_clk  (wb_clk),
      .wb_rst  (wb_rst),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_we    (m_we),
      .m_adr   (m_adr),
      .m_dat   (m_dat),
      .m_sel   (m_sel),
      .m_rdt   (m_rdt),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .s_cyc   (s_cyc),
      .s_stb   (s_stb),
      .s_we    (s_we),
      .s_adr   (s_adr),
      .s_dat   (s_dat),
      .s_sel   (s_sel),
      .s_rdt   (s_rdt),
      .s_ack   (s_ack),
      .s_err   (s_err),
      .o_grant (o_grant),
      .o_busy  (o_busy)
   );

   // ---------------- clock / reset ----------------
   always #5 wb_clk = ~wb_clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "time limit");
   end

   // ---------------- ack monitor (scoreboard pop) ----------------
   always @(negedge wb_clk) begin
      if (!wb_rst && m_ack !== '0) begin
         checks++;
         mon_got = {m_ack[1], m_rdt};
         if (m_ack === 2'b11 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: m_ack=%b queue_depth=%0d, required no ack", m_ack, exp_q.size());
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL ack_data: got master %0d rdt %h, required master %0d rdt %h",
                        mon_got[DW], mon_got[DW-1:0], mon_exp[DW], mon_exp[DW-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_adr = '0; m_dat = '0; m_sel = '0;
      s_rdt = '0; s_ack = 1'b0; s_err = 1'b0;
   endtask

   task automatic do_reset();
      wb_rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      wb_rst = 1'b0;
      tick();
   endtask

   task automatic req(input int m, input logic on, input logic [AW-1:0] adr);
      m_cyc[m] = on;
      m_stb[m] = on;
      m_we[m]  = 1'b0;
      m_adr[m*AW +: AW] = adr;
      m_dat[m*DW +: DW] = adr ^ 32'h5A5A_5A5A;
      m_sel[m*SW +: SW] = on ? 4'hF : 4'h0;
   endtask

   // Slave acks in the current cycle; checks the routing seen by the slave.
   task automatic ack_now(input int m, input logic [DW-1:0] rdt, input logic [AW-1:0] adr);
      logic [N-1:0] oh;
      logic [N:0]   tag;
      oh = '0;
      oh[m] = 1'b1;
      tag = N'(m);
      s_ack = 1'b1;
      s_rdt = rdt;
      exp_q.push_back({tag[0], rdt});
      @(negedge wb_clk);
      checks++;
      if (o_busy !== 1'b1 || o_grant !== tag[0] || s_cyc !== 1'b1 || s_adr !== adr) begin
         errors++;
         $display("FAIL ack_route: busy=%b grant=%0d s_cyc=%b s_adr=%h, required 1 %0d 1 %h",
                  o_busy, o_grant, s_cyc, s_adr, tag[0], adr);
      end
      checks++;
      if (m_ack !== oh || m_err !== '0) begin
         errors++;
         $display("FAIL ack_vector: m_ack=%b m_err=%b, required %b 00", m_ack, m_err, oh);
      end
      tick();
      s_ack = 1'b0;
   endtask

   task automatic wait_busy(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge wb_clk);
         if (o_busy === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_busy: o_busy=0 for 10 cycles, required 1");
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      wb_rst = 1'b1;
      clear_inputs();
      req(0, 1'b1, A0);
      req(1, 1'b1, A1);
      tick();
      @(negedge wb_clk);
      checks++;
      if (o_busy !== 1'b0 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== '0 ||
          m_err !== '0 || o_grant !== '0 || s_adr !== '0 || m_rdt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b s_cyc=%b s_stb=%b m_ack=%b m_err=%b grant=%0d, required all 0",
                  o_busy, s_cyc, s_stb, m_ack, m_err, o_grant);
      end
      do_reset();
   endtask

   task automatic test_first_grant();
      do_reset();
      req(0, 1'b1, A0);
      req(1, 1'b1, A1);
      @(negedge wb_clk);
      checks++;
      if (s_cyc !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL req_cycle: s_cyc=%b busy=%b, required 0 0", s_cyc, o_busy);
      end
      tick();
      ack_now(0, 32'h1111_0000, A0);
      req(0, 1'b0, '0);
      @(negedge wb_clk);
      checks++;
      if (s_cyc !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL release_cycle: s_cyc=%b busy=%b, required 0 1", s_cyc, o_busy);
      end
      tick();
      @(negedge wb_clk);
      checks++;
      if (s_cyc !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_gap: s_cyc=%b busy=%b, required 0 0", s_cyc, o_busy);
      end
      tick();
      ack_now(1, 32'h2222_0000, A1);
      req(1, 1'b0, '0);
      tick();
      tick();
   endtask

   task automatic test_bus_lock();
      do_reset();
      req(1, 1'b1, A1);
      tick();
      req(0, 1'b1, A0);
      for (int k = 0; k < 4; k++) begin
         req(1, 1'b1, A1 + AW'(4 * k));
         ack_now(1, 32'hDEAD_BEEF + DW'(k), A1 + AW'(4 * k));
      end
      req(1, 1'b0, '0);
      @(negedge wb_clk);
      checks++;
      if (m_ack !== '0 || s_cyc !== 1'b0) begin
         errors++;
         $display("FAIL lock_release: m_ack=%b s_cyc=%b, required 00 0", m_ack, s_cyc);
      end
      tick();
      tick();
      ack_now(0, 32'hA5A5_0001, A0);
      req(0, 1'b0, '0);
      tick();
      tick();
   endtask

   task automatic test_alternating();
      logic                 ok;
      logic [AW-1:0]        adr;
      logic [$clog2(N)-1:0] g;
      do_reset();
      req(0, 1'b1, A0);
      req(1, 1'b1, A1);
      for (int t = 0; t < 8; t++) begin
         g   = 1'(t % 2);
         adr = (g == 1'b0) ? A0 : A1;
         wait_busy(ok);
         checks++;
         if (o_grant !== g) begin
            errors++;
            $display("FAIL alt_grant: txn %0d grant=%0d, required %0d", t, o_grant, g);
         end
         tick();
         ack_now(int'(g), 32'h3000_0000 + DW'(t), adr);
         req(int'(g), 1'b0, '0);
         tick();
         req(int'(g), 1'b1, adr);
      end
      req(0, 1'b0, '0);
      req(1, 1'b0, '0);
      tick();
      tick();
   endtask

   task automatic test_abandon();
      do_reset();
      req(0, 1'b1, A0);
      tick();
      @(negedge wb_clk);
      checks++;
      if (o_busy !== 1'b1 || s_cyc !== 1'b1) begin
         errors++;
         $display("FAIL abandon_grant: busy=%b s_cyc=%b, required 1 1", o_busy, s_cyc);
      end
      tick();
      req(0, 1'b0, '0);
      @(negedge wb_clk);
      checks++;
      if (s_cyc !== 1'b0 || m_ack !== '0) begin
         errors++;
         $display("FAIL abandon_drop: s_cyc=%b m_ack=%b, required 0 00", s_cyc, m_ack);
      end
      tick();
      s_ack = 1'b1;
      s_rdt = 32'hBAD0_BAD0;
      @(negedge wb_clk);
      checks++;
      if (m_ack !== '0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL abandon_late_ack: m_ack=%b busy=%b, required 00 0", m_ack, o_busy);
      end
      tick();
      s_ack = 1'b0;
   endtask

   task automatic test_watchdog();
      do_reset();
      req(0, 1'b1, A0);
      tick();
`ifdef WB_ARB_WATCHDOG_EN
      for (int k = 0; k <= TIMEOUT; k++) begin
         @(negedge wb_clk);
         checks++;
         if (k < TIMEOUT) begin
            if (m_err !== '0 || s_stb !== 1'b1) begin
               errors++;
               $display("FAIL wdog_wait: cycle %0d m_err=%b s_stb=%b, required 00 1", k, m_err, s_stb);
            end
         end else begin
            if (m_err !== 2'b01 || s_stb !== 1'b0 || s_cyc !== 1'b0) begin
               errors++;
               $display("FAIL wdog_fire: m_err=%b s_stb=%b s_cyc=%b, required 01 0 0", m_err, s_stb, s_cyc);
            end
         end
         tick();
      end
      @(negedge wb_clk);
      checks++;
      if (o_busy !== 1'b0 || m_err !== '0) begin
         errors++;
         $display("FAIL wdog_idle: busy=%b m_err=%b, required 0 00", o_busy, m_err);
      end
      // Ack arriving in the timeout cycle wins over the error.
      do_reset();
      req(0, 1'b1, A0);
      tick();
      for (int k = 0; k < TIMEOUT; k++) tick();
      ack_now(0, 32'h4444_0008, A0);
      req(0, 1'b0, '0);
      tick();
`else
      for (int k = 0; k < 100; k++) begin
         @(negedge wb_clk);
         checks++;
         if (o_busy !== 1'b1 || m_err !== '0 || s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL hung_bus: cycle %0d busy=%b m_err=%b s_cyc=%b, required 1 00 1",
                     k, o_busy, m_err, s_cyc);
         end
         tick();
      end
      req(0, 1'b0, '0);
      tick();
`endif
   endtask

   task automatic test_rst_mid();
      logic ok;
      do_reset();
      req(1, 1'b1, A1);
      tick();
      s_ack = 1'b1;
      s_rdt = 32'h5555_5555;
      #2;
      wb_rst = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== '0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: s_cyc=%b s_stb=%b m_ack=%b busy=%b, required 0 0 00 0",
                  s_cyc, s_stb, m_ack, o_busy);
      end
      s_ack = 1'b0;
      req(0, 1'b1, A0);
      tick();
      tick();
      wb_rst = 1'b0;
      wait_busy(ok);
      checks++;
      if (o_grant !== 1'b0) begin
         errors++;
         $display("FAIL rst_regrant: grant=%0d, required 0", o_grant);
      end
      req(0, 1'b0, '0);
      req(1, 1'b0, '0);
      tick();
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_first_grant();
      test_bus_lock();
      test_alternating();
      test_abandon();
      test_watchdog();
      test_rst_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d acks never seen, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
